bbox_traverser: RTL and testbench
=================================

Name: bbox_traverser

Overview:
- Consumes one screen-space triangle bounding box (XMIN/XMAX/YMIN/YMAX, unsigned Q10.6, pixel-aligned) per handshake.
- Walks every pixel in the box in raster order: x fastest, then y.
- Emits one sample coordinate per cycle over a valid/ready stream to the downstream edge-function/coverage stage.
- Sits directly between bounding-box computation and per-pixel inside test in the rasterizer pipeline.

Parameters:
- WIDTH, 16, coordinate width in bits (unsigned fixed point).
- FRAC_BITS, 6, fractional bits; pixel step = 1 << FRAC_BITS (64).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- XMIN  in  WIDTH  box left edge, Q10.6.
- XMAX  in  WIDTH  box right edge, inclusive.
- YMIN  in  WIDTH  box top edge.
- YMAX  in  WIDTH  box bottom edge, inclusive.
- bbox_valid  in  1  box inputs valid.
- bbox_ready  out  1  block can accept a box.
- sample_x  out  WIDTH  current sample x, Q10.6.
- sample_y  out  WIDTH  current sample y, Q10.6.
- sample_valid  out  1  sample outputs valid.
- sample_ready  in  1  downstream accepts sample.
- sample_last  out  1  current sample is the final one of the box.
- done  out  1  one-cycle pulse: box fully traversed, or empty box discarded.
- busy  out  1  traversal in progress (state RUN).

Behaviour:
- Reset, asynchronous: state=IDLE, bbox_ready=1, sample_valid=0, sample_last=0, done=0, busy=0, sample_x=sample_y=0, internal bounds=0.
- FSM states:
  - IDLE: bbox_ready=1, no sample output.
  - RUN: bbox_ready=0, busy=1, sample_valid=1.
- Capture: box is accepted when bbox_valid && bbox_ready. On accept, the low FRAC_BITS of all four inputs are masked to zero (floor). Masked values are registered; later input changes are ignored.
- Empty box: masked XMIN > XMAX or YMIN > YMAX, compared unsigned.
  - Accepted, no samples emitted.
  - Stay IDLE; done=1 on the next cycle only.
- Non-empty box:
  - Next cycle: state=RUN, sample_x=XMIN, sample_y=YMIN, sample_valid=1. Latency from accept to first sample is 1 cycle.
- Stream rules:
  - Sample advances only on sample_valid && sample_ready.
  - While sample_ready=0, sample_x, sample_y and sample_last are held stable.
  - sample_valid never drops in RUN before the last handshake.
- Advance, one sample/cycle sustained:
  - If sample_x != xmax: sample_x += STEP.
  - Else: sample_x = xmin and sample_y += STEP.
- Termination uses equality compares (x == xmax, y == ymax), never "greater than". A box edge at 0xFFC0 therefore never wraps past 0xFFFF; the adder result is discarded when the edge is hit.
- sample_last = (sample_x == xmax) && (sample_y == ymax). It is combinational from registers and valid only with sample_valid.
- Last handshake:
  - Next cycle: state=IDLE, sample_valid=0, done=1 for one cycle, bbox_ready=1.
  - A new box is accepted at the earliest that same cycle. There is one bubble cycle between boxes.
- Single-pixel box (XMIN==XMAX, YMIN==YMAX): exactly one sample, with sample_last=1.
- bbox_valid during RUN is ignored; upstream must hold it.
- Reset mid-traversal abandons the box immediately with the reset values above. No done pulse is produced.

Optional Feature:
- Macro: BBOX_SAMPLE_CENTER_EN.
  - Defined: sample_x and sample_y are offset by +half pixel (1 << (FRAC_BITS-1), 32) at the output only. Internal counters and termination compares are unchanged.
  - Undefined: outputs are the pixel corner coordinates exactly as counted.
- The offset is output-only; it wraps modulo 2^WIDTH at the 0xFFC0 edge. Box-capture masking is unaffected.

Decomposition:
- Shared rasterizer package holds:
  - WIDTH and FRAC_BITS constants.
  - Derived PIX_STEP = 1 << FRAC_BITS and HALF_PIX.
  - FSM state encoding: IDLE, RUN.
- One natural sub-module: bbox_axis_counter. One instance per axis: load value, bound, step enable, wrap-to-min output, "at bound" flag. The x instance's wrap drives the y instance's step enable.

Test Plan:
- 2x2 box: XMIN=0x0040, XMAX=0x0080, YMIN=0x00C0, YMAX=0x0100, sample_ready=1.
  - Required samples: (0x40,0xC0), (0x80,0xC0), (0x40,0x100), (0x80,0x100) on consecutive cycles.
  - First sample 1 cycle after accept; sample_last only on the 4th; done the cycle after.
- Unaligned inputs: XMIN=0x0075, XMAX=0x00BF, YMIN=YMAX=0x0010.
  - Required: masked to 0x40..0x80 and y=0; samples (0x40,0), (0x80,0); last on 2nd.
- Backpressure: same 2x2 box with sample_ready toggling 1,0,0,1,...
  - Outputs held stable while ready=0; exactly 4 handshakes; no sample duplicated or skipped.
- Empty box: XMIN=0x0100, XMAX=0x0080.
  - Required: accepted, sample_valid never asserts, done pulses 1 cycle later, bbox_ready stays 1.
- Edge box: XMIN=XMAX=0xFFC0, YMIN=0xFF80, YMAX=0xFFC0.
  - Required: exactly 2 samples, (0xFFC0,0xFF80) then (0xFFC0,0xFFC0), with no wrap to 0.
- Reset mid-traversal: assert rst after the 2nd sample of the 2x2 box.
  - Required: all outputs at reset values immediately, no done pulse. Next box starts cleanly from its own XMIN/YMIN.

Source files
------------

// File: rtl/bbox_traverser_pkg.sv
// Shared rasterizer constants and FSM encoding for the bounding-box traverser.
package bbox_traverser_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned FRAC_BITS = 6;
  localparam int unsigned PIX_STEP  = 1 << FRAC_BITS;
  localparam int unsigned HALF_PIX  = 1 << (FRAC_BITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bbox_axis_counter.sv
// One traversal axis: holds min/bound, steps by one pixel, wraps to min at the bound.
module bbox_axis_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_min,
  input  logic [WIDTH-1:0] load_bound,
  input  logic             step_en,
  output logic [WIDTH-1:0] value,
  output logic             at_bound_c,
  output logic             wrap_c
);

  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] bound_q;
  logic [WIDTH-1:0] value_q;

  // Equality against the bound keeps a 0xFFC0 edge from ever wrapping through zero.
  assign at_bound_c = (value_q == bound_q);
  assign wrap_c     = step_en && at_bound_c;
  assign value      = value_q;

  // Load bounds on capture, otherwise step or wrap back to min.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q   <= '0;
      bound_q <= '0;
      value_q <= '0;
    end else if (load) begin
      min_q   <= load_min;
      bound_q <= load_bound;
      value_q <= load_min;
    end else if (step_en) begin
      value_q <= at_bound_c ? min_q : value_q + WIDTH'(STEP);
    end
  end

endmodule

// File: rtl/bbox_traverser.sv
// Walks every pixel of a captured bounding box in raster order, one sample per cycle.
// Optional BBOX_SAMPLE_CENTER_EN: offsets output coordinates by half a pixel.
module bbox_traverser
  import bbox_traverser_pkg::*;
#(
  parameter int unsigned WIDTH     = bbox_traverser_pkg::WIDTH,
  parameter int unsigned FRAC_BITS = bbox_traverser_pkg::FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] XMIN,
  input  logic [WIDTH-1:0] XMAX,
  input  logic [WIDTH-1:0] YMIN,
  input  logic [WIDTH-1:0] YMAX,
  input  logic             bbox_valid,
  output logic             bbox_ready,
  output logic [WIDTH-1:0] sample_x,
  output logic [WIDTH-1:0] sample_y,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             sample_last,
  output logic             done,
  output logic             busy
);

  localparam int unsigned STEP = 1 << FRAC_BITS;
  localparam int unsigned HALF = 1 << (FRAC_BITS - 1);
  localparam logic [WIDTH-1:0] MASK = ~WIDTH'(STEP - 1);

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   valid_q, valid_d;
  logic   busy_q,  busy_d;
  logic   done_q,  done_d;

  logic [WIDTH-1:0] xmin_m_c, xmax_m_c, ymin_m_c, ymax_m_c;
  logic             accept_c, advance_c, empty_c;
  logic [WIDTH-1:0] x_val, y_val;
  logic             x_at_c, y_at_c, x_wrap_c, y_wrap_c;

  // Floor inputs to the pixel grid and classify the box.
  assign xmin_m_c  = XMIN & MASK;
  assign xmax_m_c  = XMAX & MASK;
  assign ymin_m_c  = YMIN & MASK;
  assign ymax_m_c  = YMAX & MASK;
  assign empty_c   = (xmin_m_c > xmax_m_c) || (ymin_m_c > ymax_m_c);
  assign accept_c  = bbox_valid && ready_q;
  assign advance_c = valid_q && sample_ready;

  bbox_axis_counter #(.WIDTH(WIDTH), .STEP(STEP)) u_x (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_c),
    .load_min   (xmin_m_c),
    .load_bound (xmax_m_c),
    .step_en    (advance_c),
    .value      (x_val),
    .at_bound_c (x_at_c),
    .wrap_c     (x_wrap_c)
  );

  // Row advances only when the x axis wraps.
  bbox_axis_counter #(.WIDTH(WIDTH), .STEP(STEP)) u_y (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_c),
    .load_min   (ymin_m_c),
    .load_bound (ymax_m_c),
    .step_en    (x_wrap_c),
    .value      (y_val),
    .at_bound_c (y_at_c),
    .wrap_c     (y_wrap_c)
  );

  // State and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: empty boxes finish from IDLE, full boxes end on the final handshake.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (empty_c) done_d  = 1'b1;
          else         state_d = RUN;
        end
      end
      RUN: begin
        if (y_wrap_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
  end

  assign bbox_ready   = ready_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_last  = valid_q && x_at_c && y_at_c;

`ifdef BBOX_SAMPLE_CENTER_EN
  // Half-pixel offset is applied at the output only and wraps modulo 2^WIDTH.
  assign sample_x = x_val + WIDTH'(HALF);
  assign sample_y = y_val + WIDTH'(HALF);
`else
  // Pixel corner coordinates exactly as counted.
  assign sample_x = x_val;
  assign sample_y = y_val;
`endif

endmodule

// File: tb/tb_bbox_traverser.sv
// Self-checking bench for bbox_traverser: directed table, random boxes, reset sequence.
module tb_bbox_traverser;

  localparam int W    = 16;
  localparam int HALF = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] XMIN, XMAX, YMIN, YMAX;
  logic         bbox_valid;
  logic         bbox_ready;
  logic [W-1:0] sample_x, sample_y;
  logic         sample_valid;
  logic         sample_ready;
  logic         sample_last;
  logic         done;
  logic         busy;

  int n_checks;
  int n_fail;

  bbox_traverser dut (
    .clk          (clk),
    .rst          (rst),
    .XMIN         (XMIN),
    .XMAX         (XMAX),
    .YMIN         (YMIN),
    .YMAX         (YMAX),
    .bbox_valid   (bbox_valid),
    .bbox_ready   (bbox_ready),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_last  (sample_last),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] xa, xb, ya, yb;
    int           mode;   // 0: ready always, 1: ready 1,0,0 pattern, 2: random
    int           exp_n;
    string        name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] outv(input logic [W-1:0] v);
`ifdef BBOX_SAMPLE_CENTER_EN
    return v + W'(HALF);
`else
    return v;
`endif
  endfunction

  // Reference: enumerate pixel corners of the floored box in raster order.
  task automatic build_model(input logic [W-1:0] xa, xb, ya, yb,
                             output logic [W-1:0] qx[$], output logic [W-1:0] qy[$]);
    int x0, x1, y0, y1;
    qx.delete();
    qy.delete();
    x0 = int'(xa) / 64 * 64;
    x1 = int'(xb) / 64 * 64;
    y0 = int'(ya) / 64 * 64;
    y1 = int'(yb) / 64 * 64;
    for (int y = y0; y <= y1; y += 64)
      for (int x = x0; x <= x1; x += 64) begin
        qx.push_back(W'(x));
        qy.push_back(W'(y));
      end
  endtask

  // Offer one box, consume its samples under the chosen ready policy, check done.
  task automatic run_box(input logic [W-1:0] xa, xb, ya, yb, input int mode,
                         input string tag, output int n_hs);
    logic [W-1:0] qx[$];
    logic [W-1:0] qy[$];
    int  budget;
    int  k;
    logic rdy;
    build_model(xa, xb, ya, yb, qx, qy);
    n_hs = 0;
    k    = 0;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(bbox_ready), 32'd1);
    XMIN = xa; XMAX = xb; YMIN = ya; YMAX = yb;
    bbox_valid   = 1'b1;
    sample_ready = 1'b0;
    @(negedge clk);
    bbox_valid = 1'b0;
    XMIN = W'($urandom); XMAX = W'($urandom); YMIN = W'($urandom); YMAX = W'($urandom);
    if (qx.size() == 0) begin
      check({tag, " empty_done"},  32'(done),         32'd1);
      check({tag, " empty_valid"}, 32'(sample_valid), 32'd0);
      check({tag, " empty_ready"}, 32'(bbox_ready),   32'd1);
      @(negedge clk);
      check({tag, " empty_done_off"},  32'(done),         32'd0);
      check({tag, " empty_valid_off"}, 32'(sample_valid), 32'd0);
      return;
    end
    budget = qx.size() * 4 + 10;
    while (qx.size() > 0 && budget > 0) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      check({tag, " valid"},  32'(sample_valid), 32'd1);
      check({tag, " busy"},   32'(busy),         32'd1);
      check({tag, " ready"},  32'(bbox_ready),   32'd0);
      check({tag, " done"},   32'(done),         32'd0);
      check({tag, " x"},      32'(sample_x),     32'(outv(qx[0])));
      check({tag, " y"},      32'(sample_y),     32'(outv(qy[0])));
      check({tag, " last"},   32'(sample_last),  32'(qx.size() == 1));
      sample_ready = rdy;
      if (rdy) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
        n_hs++;
      end
      @(negedge clk);
      budget--;
      k++;
    end
    sample_ready = 1'b0;
    if (qx.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: %0d samples outstanding, required 0", tag, qx.size());
    end
    check({tag, " done_pulse"}, 32'(done),         32'd1);
    check({tag, " end_valid"},  32'(sample_valid), 32'd0);
    check({tag, " end_ready"},  32'(bbox_ready),   32'd1);
    check({tag, " end_busy"},   32'(busy),         32'd0);
    check({tag, " end_last"},   32'(sample_last),  32'd0);
    @(negedge clk);
    check({tag, " done_off"},   32'(done),         32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst_ready"}, 32'(bbox_ready),   32'd1);
    check({tag, " rst_valid"}, 32'(sample_valid), 32'd0);
    check({tag, " rst_last"},  32'(sample_last),  32'd0);
    check({tag, " rst_done"},  32'(done),         32'd0);
    check({tag, " rst_busy"},  32'(busy),         32'd0);
    check({tag, " rst_x"},     32'(sample_x),     32'(outv(16'h0000)));
    check({tag, " rst_y"},     32'(sample_y),     32'(outv(16'h0000)));
  endtask

  initial begin
    vec_t vecs[8];
    int   n_hs;
    logic [W-1:0] mx[$];
    logic [W-1:0] my[$];

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    XMIN = '0; XMAX = '0; YMIN = '0; YMAX = '0;
    bbox_valid   = 1'b0;
    sample_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100, 0, 4, "box2x2"};
    vecs[1] = '{16'h0075, 16'h00BF, 16'h0010, 16'h0010, 0, 2, "unaligned"};
    vecs[2] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100, 1, 4, "backpressure"};
    vecs[3] = '{16'h0100, 16'h0080, 16'h0000, 16'h0040, 0, 0, "empty_x"};
    vecs[4] = '{16'hFFC0, 16'hFFC0, 16'hFF80, 16'hFFC0, 0, 2, "edge"};
    vecs[5] = '{16'h1000, 16'h1000, 16'h0200, 16'h0200, 0, 1, "single"};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0080, 16'h0040, 0, 0, "empty_y"};
    vecs[7] = '{16'hFF40, 16'hFFC0, 16'hFFFF, 16'hFFC0, 2, 3, "edge_row"};

    foreach (vecs[i]) begin
      run_box(vecs[i].xa, vecs[i].xb, vecs[i].ya, vecs[i].yb, vecs[i].mode, vecs[i].name, n_hs);
      check({vecs[i].name, " handshakes"}, 32'(n_hs), 32'(vecs[i].exp_n));
    end

    // Reset during traversal of the 2x2 box, after the second handshake.
    @(negedge clk);
    XMIN = 16'h0040; XMAX = 16'h0080; YMIN = 16'h00C0; YMAX = 16'h0100;
    bbox_valid = 1'b1;
    @(negedge clk);
    bbox_valid   = 1'b0;
    sample_ready = 1'b1;
    check("mid first_x", 32'(sample_x), 32'(outv(16'h0040)));
    @(negedge clk);
    check("mid second_x", 32'(sample_x), 32'(outv(16'h0080)));
    check("mid second_y", 32'(sample_y), 32'(outv(16'h00C0)));
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    rst = 1'b0;
    sample_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst done", 32'(done), 32'd0);
      check("post_rst valid", 32'(sample_valid), 32'd0);
      @(negedge clk);
    end
    run_box(16'h0040, 16'h0080, 16'h00C0, 16'h0100, 0, "after_rst", n_hs);
    check("after_rst handshakes", 32'(n_hs), 32'd4);

    // Random boxes, occasionally empty, against the enumerated model.
    for (int r = 0; r < 30; r++) begin
      logic [W-1:0] xa, xb, ya, yb;
      int px, py, wx, wy;
      px = $urandom_range(1, 1000);
      py = $urandom_range(1, 1000);
      wx = $urandom_range(0, 4);
      wy = $urandom_range(0, 3);
      xa = W'(px * 64 + $urandom_range(0, 63));
      ya = W'(py * 64 + $urandom_range(0, 63));
      xb = W'((px + wx) * 64 + $urandom_range(0, 63));
      yb = W'((py + wy) * 64 + $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) xb = W'((px - 1) * 64);
      build_model(xa, xb, ya, yb, mx, my);
      run_box(xa, xb, ya, yb, 2, "rand", n_hs);
      check("rand handshakes", 32'(n_hs), 32'(mx.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
